// File: rtl/rpn_calc_if.sv
// Token, stack and result signals of the RPN sequencer, bundled with modports.
// master: token source and stack device; slave: the sequencer itself.
interface rpn_calc_if;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_is_op;
    logic [7:0] tok_data;
    logic [1:0] stk_cmd;
    logic [7:0] stk_din;
    logic [7:0] stk_dout;
    logic       res_valid;
    logic [7:0] res_data;

    modport master (
        output tok_valid, tok_is_op, tok_data, stk_dout,
        input  tok_ready, stk_cmd, stk_din, res_valid, res_data
    );

    modport slave (
        input  tok_valid, tok_is_op, tok_data, stk_dout,
        output tok_ready, stk_cmd, stk_din, res_valid, res_data
    );
endinterface

// File: rtl/rpn_calc.sv
// Postfix expression sequencer driving an 8-entry, 8-bit hardware stack.
// Optional multiplier enabled by defining RPN_CALC_MUL_EN.
module rpn_calc_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [3:0] depth,
    input logic       err,
    input logic [1:0] stk_cmd,
    input logic       res_valid
);
    a_depth_range: assert property (@(posedge clk) disable iff (!rst_n) depth <= 4'd8);
    a_err_quiet:   assert property (@(posedge clk) disable iff (!rst_n) err |-> (stk_cmd == 2'b00));
    a_res_pulse:   assert property (@(posedge clk) disable iff (!rst_n) res_valid |=> !res_valid);
endmodule

module rpn_calc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    output logic       err,
    output logic [3:0] depth,
    rpn_calc_if.slave  bus
);
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_PUSH, S_POP_A, S_WAIT_A, S_POP_B,
        S_WAIT_B, S_EXEC, S_PUSH_R, S_OUT, S_ERR
    } state_e;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b10;
    localparam logic [1:0] OP_EQ    = 2'b11;
    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_CLR  = 2'b01;
    localparam logic [1:0] CMD_PUSH = 2'b10;
    localparam logic [1:0] CMD_POP  = 2'b11;

    state_e     state_q, state_d;
    logic [3:0] depth_q, depth_d;
    logic [1:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [1:0] stk_cmd_q, stk_cmd_d;
    logic [7:0] stk_din_q, stk_din_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       err_q, err_d;

    function automatic logic [1:0] cmd_of(input state_e s);
        logic [1:0] c;
        case (s)
            S_INIT:           c = CMD_CLR;
            S_PUSH, S_PUSH_R: c = CMD_PUSH;
            S_POP_A, S_POP_B: c = CMD_POP;
            default:          c = CMD_NOP;
        endcase
        return c;
    endfunction

    // b is the older operand, a the newer one
    function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] b, input logic [7:0] a);
        logic [7:0] r;
`ifdef RPN_CALC_MUL_EN
        logic [15:0] prod;
        prod = {8'h00, b} * {8'h00, a};
`endif
        case (op)
            OP_ADD:  r = b + a;
            OP_SUB:  r = b - a;
`ifdef RPN_CALC_MUL_EN
            OP_MUL:  r = prod[7:0];
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign bus.tok_ready = (state_q == S_IDLE) & ~clr;
    assign bus.stk_cmd   = stk_cmd_q;
    assign bus.stk_din   = stk_din_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign err           = err_q;
    assign depth         = depth_q;

    // Next-state, depth bookkeeping and registered-output decode
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        if (clr) begin
            state_d = S_INIT;
            depth_d = 4'd0;
        end else begin
            case (state_q)
                S_INIT: begin
                    state_d = S_IDLE;
                    depth_d = 4'd0;
                end
                S_IDLE: begin
                    if (bus.tok_valid) begin
                        if (!bus.tok_is_op) begin
                            state_d = (depth_q == 4'd8) ? S_ERR : S_PUSH;
                        end else begin
                            op_d = bus.tok_data[1:0];
                            case (bus.tok_data[1:0])
                                OP_EQ:   state_d = (depth_q == 4'd0) ? S_ERR : S_POP_A;
`ifdef RPN_CALC_MUL_EN
                                OP_MUL:  state_d = (depth_q < 4'd2) ? S_ERR : S_POP_A;
`else
                                OP_MUL:  state_d = S_ERR;
`endif
                                default: state_d = (depth_q < 4'd2) ? S_ERR : S_POP_A;
                            endcase
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PUSH: begin
                    state_d = S_IDLE;
                    depth_d = depth_q + 4'd1;
                end
                S_POP_A: state_d = S_WAIT_A;
                // Binary ops account for both pops here; the result push adds one back
                S_WAIT_A: begin
                    a_d = bus.stk_dout;
                    if (op_q == OP_EQ) begin
                        state_d = S_OUT;
                        depth_d = depth_q - 4'd1;
                    end else begin
                        state_d = S_POP_B;
                        depth_d = depth_q - 4'd2;
                    end
                end
                S_POP_B: state_d = S_WAIT_B;
                S_WAIT_B: begin
                    b_d     = bus.stk_dout;
                    state_d = S_EXEC;
                end
                S_EXEC: state_d = S_PUSH_R;
                S_PUSH_R: begin
                    state_d = S_IDLE;
                    depth_d = depth_q + 4'd1;
                end
                S_OUT: state_d = S_IDLE;
                S_ERR: state_d = S_ERR;
                default: state_d = S_INIT;
            endcase
        end

        stk_cmd_d = cmd_of(state_d);
        if (state_d == S_PUSH) begin
            stk_din_d = bus.tok_data;
        end else if (state_d == S_PUSH_R) begin
            stk_din_d = alu(op_q, b_q, a_q);
        end else begin
            stk_din_d = 8'h00;
        end
        res_valid_d = (state_d == S_OUT);
        res_data_d  = (state_d == S_OUT) ? bus.stk_dout : res_data_q;
        err_d       = (state_d == S_ERR);
    end

    // State, operand and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            depth_q     <= 4'd0;
            op_q        <= 2'b00;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            stk_cmd_q   <= CMD_CLR;
            stk_din_q   <= 8'h00;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            stk_cmd_q   <= stk_cmd_d;
            stk_din_q   <= stk_din_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    rpn_calc_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .depth     (depth_q),
        .err       (err_q),
        .stk_cmd   (stk_cmd_q),
        .res_valid (res_valid_q)
    );
endmodule

// File: tb/tb_rpn_calc.sv
// Random and directed token streams against a queue-based RPN model and a mock stack.
module tb_rpn_calc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       err;
    logic [3:0] depth;
    int         total = 0;
    int         bad = 0;
    bit         merr = 1'b0;
    int         mstk[$];
    logic [7:0] exp_q[$];
    logic [7:0] mock[$];
    logic [7:0] mon_e;

    rpn_calc_if bus ();

    rpn_calc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .err   (err),
        .depth (depth),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Mock stack device: obeys stk_cmd, flags illegal commands
    always @(posedge clk) begin
        case (bus.stk_cmd)
            2'b01: mock.delete();
            2'b10: begin
                total++;
                if (mock.size() >= 8) begin
                    bad++;
                    $display("FAIL stack push when full: size %0d", mock.size());
                end else begin
                    mock.push_back(bus.stk_din);
                end
            end
            2'b11: begin
                total++;
                if (mock.size() == 0) begin
                    bad++;
                    $display("FAIL stack pop when empty");
                end else begin
                    bus.stk_dout <= mock.pop_back();
                end
            end
            default: ;
        endcase
    end

    // Result monitor: every res_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL result unexpected: got %02h, none pending", bus.res_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.res_data !== mon_e) begin
                    bad++;
                    $display("FAIL result: got %02h expected %02h", bus.res_data, mon_e);
                end
            end
        end
    end

    // In error the stack must see no commands
    always @(negedge clk) begin
        if (rst_n && err) begin
            total++;
            if (bus.stk_cmd !== 2'b00) begin
                bad++;
                $display("FAIL cmd during err: got %0b expected 00", bus.stk_cmd);
            end
        end
    end

    // Reference: 0 operand pushed, 1 binary op, 2 EQ, 3 error
    function automatic int model_apply(input bit op, input logic [7:0] d);
        int a, b, r;
        logic [1:0] code;
        code = d[1:0];
        if (!op) begin
            if (mstk.size() == 8) return 3;
            mstk.push_back(int'(d));
            return 0;
        end
        if (code == 2'b11) begin
            if (mstk.size() == 0) return 3;
            a = mstk.pop_back();
            exp_q.push_back(8'(a));
            return 2;
        end
`ifndef RPN_CALC_MUL_EN
        if (code == 2'b10) return 3;
`endif
        if (mstk.size() < 2) return 3;
        a = mstk.pop_back();
        b = mstk.pop_back();
        if (code == 2'b00) r = b + a;
        else if (code == 2'b01) r = b - a;
        else r = b * a;
        mstk.push_back(r & 255);
        return 1;
    endfunction

    task automatic issue(input bit op, input logic [7:0] d, output int kind);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.tok_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready wait", 32'(bus.tok_ready), 32'd1);
        if (!bus.tok_ready) begin
            kind = -1;
            return;
        end
        bus.tok_valid = 1'b1;
        bus.tok_is_op = op;
        bus.tok_data  = d;
        @(posedge clk);
        kind = model_apply(op, d);
        #1;
        bus.tok_valid = 1'b0;
        bus.tok_data  = 8'h00;
    endtask

    task automatic send(input bit op, input logic [7:0] d);
        int kind, cyc, lat;
        issue(op, d, kind);
        if (kind < 0) return;
        @(negedge clk);
        if (kind == 3) begin
            check("err entry", 32'(err), 32'd1);
            check("err depth", 32'(depth), 32'(mstk.size()));
            check("err ready", 32'(bus.tok_ready), 32'd0);
            merr = 1'b1;
            return;
        end
        cyc = 1;
        while (!bus.tok_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        lat = (kind == 0) ? 2 : (kind == 1) ? 7 : 4;
        check("latency", 32'(cyc), 32'(lat));
        check("depth", 32'(depth), 32'(mstk.size()));
        check("err idle", 32'(err), 32'd0);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        bus.tok_valid = 1'b1;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = 8'hAA;
        #1;
        check("ready under clr", 32'(bus.tok_ready), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_data  = 8'h00;
        @(negedge clk);
        check("clr init cmd", 32'(bus.stk_cmd), 32'd1);
        check("clr err", 32'(err), 32'd0);
        check("clr depth", 32'(depth), 32'd0);
        @(negedge clk);
        check("clr ready", 32'(bus.tok_ready), 32'd1);
        mstk.delete();
        merr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, r;
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = 8'h00;
        bus.stk_dout  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst cmd", 32'(bus.stk_cmd), 32'd1);
        check("rst ready", 32'(bus.tok_ready), 32'd0);
        check("rst din", 32'(bus.stk_din), 32'd0);
        check("rst res_valid", 32'(bus.res_valid), 32'd0);
        check("rst res_data", 32'(bus.res_data), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst depth", 32'(depth), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("init done ready", 32'(bus.tok_ready), 32'd1);
        check("init done cmd", 32'(bus.stk_cmd), 32'd0);

        send(1'b0, 8'd5); send(1'b0, 8'd3); send(1'b1, 8'd1); send(1'b1, 8'd3);
        send(1'b0, 8'd3); send(1'b0, 8'd5); send(1'b1, 8'd1); send(1'b1, 8'd3);

        send(1'b0, 8'd20); send(1'b0, 8'd13); send(1'b1, 8'd2);
        if (merr) do_clr();
        else send(1'b1, 8'd3);

        for (int i = 1; i <= 9; i++) send(1'b0, 8'(i));
        if (merr) do_clr();
        else check("overflow flagged", 32'(merr), 32'd1);

        send(1'b0, 8'd5); send(1'b1, 8'd0);
        check("add underflow", 32'(merr), 32'd1);
        do_clr();
        send(1'b1, 8'd3);
        check("eq underflow", 32'(merr), 32'd1);
        do_clr();

        // clr during WAIT_B of an ADD abandons the op
        send(1'b0, 8'd1); send(1'b0, 8'd2);
        issue(1'b1, 8'd0, kind);
        repeat (4) @(negedge clk);
        check("waitb cmd", 32'(bus.stk_cmd), 32'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr mid cmd", 32'(bus.stk_cmd), 32'd1);
        check("clr mid depth", 32'(depth), 32'd0);
        mstk.delete();
        @(negedge clk);
        check("no push_r cmd", 32'(bus.stk_cmd), 32'd0);
        check("clr mid ready", 32'(bus.tok_ready), 32'd1);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) send(1'b0, 8'($urandom));
            else if (r < 8) send(1'b1, 8'($urandom_range(0, 2)));
            else send(1'b1, 8'd3);
            if (merr) do_clr();
        end

        // async reset in the middle of an ADD
        send(1'b0, 8'd4); send(1'b1, 8'd3);
        send(1'b0, 8'd7); send(1'b0, 8'd9);
        check("res hold", 32'(bus.res_data), 32'h04);
        issue(1'b1, 8'd0, kind);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst ready", 32'(bus.tok_ready), 32'd0);
        check("arst cmd", 32'(bus.stk_cmd), 32'd1);
        check("arst din", 32'(bus.stk_din), 32'd0);
        check("arst res_valid", 32'(bus.res_valid), 32'd0);
        check("arst res_data", 32'(bus.res_data), 32'd0);
        check("arst err", 32'(err), 32'd0);
        check("arst depth", 32'(depth), 32'd0);
        mstk.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst recover ready", 32'(bus.tok_ready), 32'd1);
        send(1'b0, 8'd200); send(1'b0, 8'd100); send(1'b1, 8'd0); send(1'b1, 8'd3);

        repeat (5) @(negedge clk);
        check("pending results", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
